sar_adc_ctrl: RTL

- Digital successive-approximation controller for the microse analog front end.
- Drives the sample/hold switch and the capacitive-DAC trial code into the analog macro on ua[].
- Takes back the asynchronous comparator decision and returns an NBITS result with a valid strobe to the digital side (uo_out/uio).
- Sits directly beside the analog macro inside the tt_um top and is the only block that sequences it.

---
 rtl/microse_pkg.sv | 31 +++
 rtl/sar_adc_ctrl_if.sv | 48 ++++
 rtl/microse_sync2.sv | 34 +++
 rtl/sar_adc_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/microse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microse_pkg
// Description : Shared types and constants for the microse SAR ADC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package microse_pkg;

  // Controller sequencing states; two bits cover all four phases.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Default build of the converter.
  localparam int c_NBITS_DEFAULT         = 8;
  localparam int c_SAMPLE_CYCLES_DEFAULT = 4;
  localparam int c_SETTLE_CYCLES_DEFAULT = 2;

  // Depth of the comparator synchronizer; the bit period budgets for it.
  localparam int c_SYNC_STAGES = 2;

  // Larger of two integers, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_adc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl_if
// Description : Control/data bundle between the SAR controller, the analog
//               macro (sample switch, C-DAC, comparator) and the digital side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_adc_ctrl_if
  import microse_pkg::*;
#(
  parameter int NBITS = c_NBITS_DEFAULT
);

  logic             start;
  logic             cont;
  logic             comp_in;
  logic             sample_en;
  logic [NBITS-1:0] dac_code;
  logic [NBITS-1:0] result;
  logic             valid;
  logic             busy;

  // Digital side plus analog macro: issues requests, returns the comparator.
  modport master (
    output start,
    output cont,
    output comp_in,
    input  sample_en,
    input  dac_code,
    input  result,
    input  valid,
    input  busy
  );

  // The SAR controller itself.
  modport slave (
    input  start,
    input  cont,
    input  comp_in,
    output sample_en,
    output dac_code,
    output result,
    output valid,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/microse_sync2.sv
`default_nettype none
// ============================================================================
// Module      : microse_sync2
// Description : Generic two-flop synchronizer with asynchronous active-high
//               reset; brings an asynchronous level into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module microse_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation controller. Samples the input,
//               walks the C-DAC trial code MSB to LSB using the synchronized
//               comparator decision, and publishes an NBITS result with a
//               one-cycle valid strobe. Optional continuous reconversion.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl
  import microse_pkg::*;
#(
  parameter int NBITS         = c_NBITS_DEFAULT,
  parameter int SAMPLE_CYCLES = c_SAMPLE_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sar_adc_ctrl_if.slave  bus
);

  // One bit period = DAC settle time plus the synchronizer latency.
  localparam int c_BIT_PERIOD = SETTLE_CYCLES + c_SYNC_STAGES;
  localparam int c_CNT_W      = $clog2(max_int(SAMPLE_CYCLES, c_BIT_PERIOD));
  localparam int c_IDX_W      = $clog2(NBITS);

  // Counters count down to zero, so reloads are period minus one.
  localparam logic [c_CNT_W-1:0] c_SAMPLE_LOAD = c_CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LOAD    = c_CNT_W'(c_BIT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_MSB     = c_IDX_W'(NBITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE     = c_IDX_W'(1);
  localparam logic [NBITS-1:0]   c_MSB_MASK    = {1'b1, {(NBITS-1){1'b0}}};

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_IDX_W-1:0] r_bit_idx;
  logic [NBITS-1:0]   r_working;
  logic               r_sample_en;
  logic [NBITS-1:0]   r_dac_code;
  logic [NBITS-1:0]   r_result;
  logic               r_valid;
  logic               r_busy;

  logic               w_comp_s;
  logic [NBITS-1:0]   w_bit_mask;
  logic [NBITS-1:0]   w_working_upd;

  // Comparator output is asynchronous to clk; resynchronize before use.
  microse_sync2 #(
    .WIDTH (1)
  ) u_comp_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.comp_in),
    .o_q (w_comp_s)
  );

  // Trial bit under test and the working value with its decision folded in.
  always_comb begin
    w_bit_mask    = NBITS'(1) << r_bit_idx;
    w_working_upd = w_comp_s ? (r_working | w_bit_mask) : r_working;
  end

  // Sequencer: state, counters, working register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_working   <= '0;
      r_sample_en <= 1'b0;
      r_dac_code  <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= SAMPLE;
            r_cnt       <= c_SAMPLE_LOAD;
            r_sample_en <= 1'b1;
            r_dac_code  <= '0;
            r_busy      <= 1'b1;
          end
        end

        SAMPLE: begin
          if (r_cnt == '0) begin
            r_state     <= CONVERT;
            r_cnt       <= c_BIT_LOAD;
            r_bit_idx   <= c_IDX_MSB;
            r_working   <= '0;
            r_sample_en <= 1'b0;
            r_dac_code  <= c_MSB_MASK;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        CONVERT: begin
          if (r_cnt == '0) begin
            r_working <= w_working_upd;
            if (r_bit_idx == '0) begin
              // Last decision: publish straight from the updated value.
              r_state    <= DONE;
              r_result   <= w_working_upd;
              r_valid    <= 1'b1;
              r_dac_code <= '0;
            end else begin
              r_bit_idx  <= r_bit_idx - c_IDX_ONE;
              r_cnt      <= c_BIT_LOAD;
              r_dac_code <= w_working_upd | (w_bit_mask >> 1);
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        DONE: begin
          if (bus.cont) begin
            r_state     <= SAMPLE;
            r_cnt       <= c_SAMPLE_LOAD;
            r_sample_en <= 1'b1;
            r_dac_code  <= '0;
            r_busy      <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_sample_en <= 1'b0;
          r_dac_code  <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_en = r_sample_en;
  assign bus.dac_code  = r_dac_code;
  assign bus.result    = r_result;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire
